dcm_lock_supervisor: RTL and testbench

Lock supervisor for the n210 clock service. Runs on the free-running reference clock that also feeds the DCM and watches the DCM `locked` output. It drives the DCM reset with a bounded pulse and restarts the DCM when lock is not reached in time. After lock has been stable for a qualification window, it releases an active-low system reset. It also keeps retry and lock-loss statistics and stops with a sticky fail flag when retries are exhausted.

---
 rtl/dcm_lock_supervisor.sv | 143 ++++++++++++++
 tb/tb_dcm_lock_supervisor.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcm_lock_supervisor.sv
// dcm_lock_supervisor: sequences the DCM reset, qualifies lock, then releases the active-low system reset.
// Latency: lockedIn reaches the FSM after a 2-flop synchronizer; every output is registered (changes with state).
// No flow control: a lock timeout or a lock loss during hold triggers a retry; the FSM parks in FAIL when retries run out.
module dcm_lock_supervisor #(
  parameter int RST_PULSE    = 4,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int HOLD_CYCLES  = 1024,
  parameter int MAX_RETRY    = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lockedIn,
  output logic        dcmRst,
  output logic        sysRstn,
  output logic [2:0]  state,
  output logic [2:0]  retryCount,
  output logic [15:0] unlockCount,
  output logic        fail
);

  typedef enum logic [2:0] {
    RESET_DCM = 3'd0,
    WAIT_LOCK = 3'd1,
    HOLD      = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  // Terminal counts: cnt is cleared on every state change, so each is "cycles in state - 1".
  localparam logic [31:0] PULSE_LAST   = 32'(RST_PULSE - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(LOCK_TIMEOUT - 1);
  localparam logic [31:0] HOLD_LAST    = 32'(HOLD_CYCLES - 1);
  localparam logic [2:0]  RETRY_LIMIT  = 3'(MAX_RETRY);

  state_t      cur;
  state_t      nxt;
  logic        sync1;
  logic        lock_s;
  logic [31:0] cnt;
  logic        retry_inc;
  logic        retry_clr;
  logic        unlock_inc;
  logic [2:0]  retry_next;

  assign retry_next = retryCount + 3'd1;
  assign state      = cur;

  // Bring the asynchronous DCM lock into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= lockedIn;
      lock_s <= sync1;
    end
  end

  // Next-state decode plus the counter update requests for this transition.
  always_comb begin
    nxt        = cur;
    retry_inc  = 1'b0;
    retry_clr  = 1'b0;
    unlock_inc = 1'b0;
    case (cur)
      RESET_DCM: begin
        if (cnt == PULSE_LAST) nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock is checked first so it wins over a coincident timeout.
        if (lock_s) begin
          nxt = HOLD;
        end else if (cnt == TIMEOUT_LAST) begin
          retry_inc = 1'b1;
          nxt       = (retry_next == RETRY_LIMIT) ? FAIL : RESET_DCM;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          retry_inc = 1'b1;
          nxt       = (retry_next == RETRY_LIMIT) ? FAIL : RESET_DCM;
        end else if (cnt == HOLD_LAST) begin
          retry_clr = 1'b1;
          nxt       = RUN;
        end
      end
      RUN: begin
        if (!lock_s) begin
          unlock_inc = 1'b1;
          nxt        = RESET_DCM;
        end
      end
      FAIL: begin
        nxt = FAIL;
      end
      default: begin
        nxt = RESET_DCM;
      end
    endcase
  end

  // State register and the shared per-state cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= RESET_DCM;
      cnt <= 32'd0;
    end else begin
      cur <= nxt;
      cnt <= (nxt != cur) ? 32'd0 : cnt + 32'd1;
    end
  end

  // Outputs are decoded from the next state so they move on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      dcmRst  <= 1'b1;
      sysRstn <= 1'b0;
      fail    <= 1'b0;
    end else begin
      dcmRst  <= (nxt == RESET_DCM);
      sysRstn <= (nxt == RUN);
      fail    <= (nxt == FAIL);
    end
  end

  // Retry and lock-loss statistics; unlockCount saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      retryCount  <= 3'd0;
      unlockCount <= 16'd0;
    end else begin
      if (retry_clr) begin
        retryCount <= 3'd0;
      end else if (retry_inc) begin
        retryCount <= retry_next;
      end
      if (unlock_inc && (unlockCount != 16'hFFFF)) begin
        unlockCount <= unlockCount + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dcm_lock_supervisor.sv
// tb_dcm_lock_supervisor: directed vectors with hand-computed expectations for the lock supervisor.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_dcm_lock_supervisor;

  logic        clk;
  logic        rst;
  logic        lockedIn;
  logic        dcmRst;
  logic        sysRstn;
  logic [2:0]  state;
  logic [2:0]  retryCount;
  logic [15:0] unlockCount;
  logic        fail;

  int n_vec;
  int n_bad;

  dcm_lock_supervisor #(
    .RST_PULSE   (4),
    .LOCK_TIMEOUT(20),
    .HOLD_CYCLES (8),
    .MAX_RETRY   (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lockedIn   (lockedIn),
    .dcmRst     (dcmRst),
    .sysRstn    (sysRstn),
    .state      (state),
    .retryCount (retryCount),
    .unlockCount(unlockCount),
    .fail       (fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Cycles until dcmRst drops, starting from a sample where it is high.
  task automatic count_high(output int n);
    n = 0;
    while (dcmRst && n < 100) begin
      tick(1);
      n++;
    end
  endtask

  // Wait for the next dcmRst rise, then measure how long it stays high.
  task automatic pulse_width(output int n);
    int w;
    w = 0;
    while (!dcmRst && w < 200) begin
      tick(1);
      w++;
    end
    count_high(n);
  endtask

  task automatic count_until_run(output int n);
    n = 0;
    while (!sysRstn && n < 200) begin
      tick(1);
      n++;
    end
  endtask

  task automatic count_low(output int n);
    n = 0;
    while (!dcmRst && !fail && n < 100) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    n_vec    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    lockedIn = 1'b0;
    tick(3);

    // Reset state
    check("rst_state",   32'(state), 0);
    check("rst_dcmrst",  32'(dcmRst), 1);
    check("rst_sysrstn", 32'(sysRstn), 0);
    check("rst_retry",   32'(retryCount), 0);
    check("rst_unlock",  32'(unlockCount), 0);
    check("rst_fail",    32'(fail), 0);

    // Nominal bring-up
    rst = 1'b0;
    count_high(n);
    check("boot_pulse_w", 32'(n), 4);
    check("boot_wait_state", 32'(state), 1);
    tick(9);
    lockedIn = 1'b1;
    tick(4);
    check("boot_hold_state", 32'(state), 2);
    check("boot_hold_sysrstn", 32'(sysRstn), 0);
    tick(6);
    check("boot_sysrstn_early", 32'(sysRstn), 0);
    tick(1);
    check("boot_sysrstn_11", 32'(sysRstn), 1);
    check("boot_run_state", 32'(state), 3);
    check("boot_retry", 32'(retryCount), 0);
    check("boot_run_dcmrst", 32'(dcmRst), 0);

    // Lock loss in RUN
    tick(5);
    lockedIn = 1'b0;
    tick(2);
    check("loss_sysrstn_t2", 32'(sysRstn), 1);
    check("loss_dcmrst_t2", 32'(dcmRst), 0);
    tick(1);
    check("loss_sysrstn_t3", 32'(sysRstn), 0);
    check("loss_dcmrst_t3", 32'(dcmRst), 1);
    check("loss_unlock", 32'(unlockCount), 1);
    check("loss_state", 32'(state), 0);
    lockedIn = 1'b1;
    count_high(n);
    check("loss_pulse_w", 32'(n), 4);
    count_until_run(n);
    check("loss_relock_cycles", 32'(n), 9);
    check("loss_retry", 32'(retryCount), 0);

    // Saturation of unlockCount
    tick(2);
    force dut.unlockCount = 16'hFFFE;
    tick(1);
    release dut.unlockCount;
    tick(1);
    check("sat_preload", 32'(unlockCount), 32'hFFFE);
    for (int k = 0; k < 2; k++) begin
      lockedIn = 1'b0;
      tick(3);
      check("sat_unlock", 32'(unlockCount), 32'hFFFF);
      check("sat_state", 32'(state), 0);
      lockedIn = 1'b1;
      count_until_run(n);
      check("sat_relock_cycles", 32'(n), 13);
    end

    // Hold disqualification
    lockedIn = 1'b0;
    pulse_width(n);
    check("disq_pulse0_w", 32'(n), 4);
    lockedIn = 1'b1;
    tick(5);
    lockedIn = 1'b0;
    tick(2);
    check("disq_hold_state", 32'(state), 2);
    tick(1);
    check("disq_state", 32'(state), 0);
    check("disq_retry", 32'(retryCount), 1);
    check("disq_dcmrst", 32'(dcmRst), 1);
    lockedIn = 1'b1;
    count_high(n);
    check("disq_pulse1_w", 32'(n), 4);
    check("disq_retry_wait", 32'(retryCount), 1);
    count_until_run(n);
    check("disq_hold_cycles", 32'(n), 9);
    check("disq_retry_run", 32'(retryCount), 0);

    // Timeout retries to FAIL
    lockedIn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse_width(n);
      check("to_pulse_w", 32'(n), 4);
      count_low(n);
      check("to_wait_len", 32'(n), 20);
      if (i < 2) begin
        check("to_retry", 32'(retryCount), 32'(i + 1));
        check("to_state_reset", 32'(state), 0);
      end
    end
    check("to_fail_state", 32'(state), 4);
    check("to_fail_flag", 32'(fail), 1);
    check("to_fail_retry", 32'(retryCount), 3);
    check("to_fail_dcmrst", 32'(dcmRst), 0);
    tick(30);
    check("to_fail_dcmrst_late", 32'(dcmRst), 0);
    check("to_fail_state_late", 32'(state), 4);
    check("to_fail_sysrstn_late", 32'(sysRstn), 0);

    // Reset from FAIL
    rst = 1'b1;
    tick(1);
    check("rstf_state", 32'(state), 0);
    check("rstf_dcmrst", 32'(dcmRst), 1);
    check("rstf_sysrstn", 32'(sysRstn), 0);
    check("rstf_fail", 32'(fail), 0);
    check("rstf_retry", 32'(retryCount), 0);
    check("rstf_unlock", 32'(unlockCount), 0);

    // Reset during HOLD
    rst = 1'b0;
    count_high(n);
    check("rsth_pulse_w", 32'(n), 4);
    lockedIn = 1'b1;
    tick(5);
    check("rsth_hold_state", 32'(state), 2);
    rst = 1'b1;
    tick(1);
    check("rsth_state", 32'(state), 0);
    check("rsth_dcmrst", 32'(dcmRst), 1);
    check("rsth_sysrstn", 32'(sysRstn), 0);
    check("rsth_fail", 32'(fail), 0);
    check("rsth_retry", 32'(retryCount), 0);
    rst = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
